// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide memory controller:
// LSB access type codes, IO space selector and FSM state encoding.
package mem_ctrl_pkg;

   localparam logic [3:0] LB  = 4'b0000;
   localparam logic [3:0] LH  = 4'b0001;
   localparam logic [3:0] LW  = 4'b0010;
   localparam logic [3:0] LBU = 4'b0100;
   localparam logic [3:0] LHU = 4'b0101;
   localparam logic [3:0] SB  = 4'b1000;
   localparam logic [3:0] SH  = 4'b1001;
   localparam logic [3:0] SW  = 4'b1010;

   localparam logic [1:0] IO_HI_SEL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE
   } state_e;

   // Index of the final byte beat for an access type.
   function automatic logic [1:0] last_beat(input logic [3:0] t);
      unique case (t[1:0])
         2'b00:   last_beat = 2'd0;
         2'b01:   last_beat = 2'd1;
         default: last_beat = 2'd3;
      endcase
   endfunction

   // Sign or zero extension of an assembled load word.
   function automatic logic [31:0] extend(input logic [31:0] w,
                                          input logic [3:0]  t);
      unique case (1'b1)
         (t == LB):  extend = {{24{w[7]}}, w[7:0]};
         (t == LH):  extend = {{16{w[15]}}, w[15:0]};
         (t == LBU): extend = {24'd0, w[7:0]};
         (t == LHU): extend = {16'd0, w[15:0]};
         default:    extend = w;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO sequencer arbitrating ifetch and LSB,
// splitting accesses into byte beats and assembling loads.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter logic [1:0] IO_HI     = IO_HI_SEL,
   parameter bit         LSB_FIRST = 1'b1
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clear,
   input  logic        io_buffer_full,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        lsb_req,
   input  logic [3:0]  lsb_type,
   input  logic [31:0] lsb_addr,
   input  logic [31:0] lsb_wdata,
   output logic        lsb_done,
   output logic [31:0] lsb_rdata
);

   state_e      state_q;
   logic        owner_q;
   logic [3:0]  type_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] data_q;
   logic [1:0]  cnt_q;
   logic [1:0]  last_q;
   logic        rr_q;
   logic [31:0] mem_a_q;
   logic [7:0]  mem_dout_q;
   logic        mem_wr_q;
   logic        if_done_q;
   logic        lsb_done_q;
   logic [31:0] if_data_q;
   logic [31:0] lsb_rdata_q;

   logic        gnt_lsb_d;
   logic        accept_d;
   logic [31:0] acc_addr_d;
   logic [3:0]  acc_type_d;
   logic        acc_stall_d;
   logic [1:0]  cnt_d;
   logic [31:0] next_a_d;
   logic [7:0]  next_byte_d;
   logic        next_stall_d;
   logic        cur_stall_d;
   logic [31:0] word_d;
   logic [31:0] rdata_d;

   assign mem_dout  = mem_dout_q;
   assign mem_a     = mem_a_q;
   assign mem_wr    = mem_wr_q & rdy_in;
   assign if_done   = if_done_q;
   assign if_data   = if_data_q;
   assign lsb_done  = lsb_done_q;
   assign lsb_rdata = lsb_rdata_q;

   // Pick the requester to serve and the access it describes.
   always_comb begin
      gnt_lsb_d   = lsb_req && (LSB_FIRST || !if_req || !rr_q);
      accept_d    = (lsb_req || if_req) && !clear;
      acc_addr_d  = gnt_lsb_d ? lsb_addr : if_addr;
      acc_type_d  = gnt_lsb_d ? lsb_type : LW;
      acc_stall_d = io_buffer_full && (acc_addr_d[17:16] == IO_HI);
   end

   // Next-beat address, store byte and IO stall conditions.
   always_comb begin
      cnt_d        = cnt_q + 2'd1;
      next_a_d     = addr_q + {30'd0, cnt_d};
      next_byte_d  = wdata_q[{cnt_d, 3'b000} +: 8];
      next_stall_d = io_buffer_full && (next_a_d[17:16] == IO_HI);
      cur_stall_d  = io_buffer_full && (mem_a_q[17:16] == IO_HI);
   end

   // Merge the arriving byte into the load word and extend it.
   always_comb begin
      word_d                        = data_q;
      word_d[{cnt_q, 3'b000} +: 8] = mem_din;
      rdata_d                       = extend(word_d, type_q);
   end

   // Controller FSM with registered memory and handshake outputs.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q     <= S_IDLE;
         owner_q     <= 1'b0;
         type_q      <= LW;
         addr_q      <= '0;
         wdata_q     <= '0;
         data_q      <= '0;
         cnt_q       <= '0;
         last_q      <= '0;
         rr_q        <= 1'b0;
         mem_a_q     <= '0;
         mem_dout_q  <= '0;
         mem_wr_q    <= 1'b0;
         if_done_q   <= 1'b0;
         lsb_done_q  <= 1'b0;
         if_data_q   <= '0;
         lsb_rdata_q <= '0;
      end else if (rdy_in) begin
         if_done_q  <= 1'b0;
         lsb_done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (accept_d) begin
                  owner_q <= gnt_lsb_d;
                  rr_q    <= gnt_lsb_d;
                  type_q  <= acc_type_d;
                  addr_q  <= acc_addr_d;
                  wdata_q <= lsb_wdata;
                  data_q  <= '0;
                  cnt_q   <= '0;
                  last_q  <= last_beat(acc_type_d);
                  mem_a_q <= acc_addr_d;
                  if (gnt_lsb_d && lsb_type[3]) begin
                     state_q    <= S_WRITE;
                     mem_dout_q <= lsb_wdata[7:0];
                     mem_wr_q   <= !acc_stall_d;
                  end else begin
                     state_q  <= S_READ;
                     mem_wr_q <= 1'b0;
                  end
               end
            end
            S_READ: begin
               if (clear) begin
                  state_q  <= S_IDLE;
                  mem_a_q  <= '0;
                  mem_wr_q <= 1'b0;
               end else begin
                  data_q <= word_d;
                  if (cnt_q == last_q) begin
                     state_q <= S_DONE;
                     mem_a_q <= '0;
                     if (owner_q) begin
                        lsb_done_q  <= 1'b1;
                        lsb_rdata_q <= rdata_d;
                     end else begin
                        if_done_q <= 1'b1;
                        if_data_q <= rdata_d;
                     end
                  end else begin
                     cnt_q   <= cnt_d;
                     mem_a_q <= next_a_d;
                  end
               end
            end
            S_WRITE: begin
               if (!mem_wr_q) begin
                  mem_wr_q <= !cur_stall_d;
               end else if (cnt_q == last_q) begin
                  state_q    <= S_DONE;
                  mem_wr_q   <= 1'b0;
                  mem_a_q    <= '0;
                  lsb_done_q <= 1'b1;
               end else begin
                  cnt_q      <= cnt_d;
                  mem_a_q    <= next_a_d;
                  mem_dout_q <= next_byte_d;
                  mem_wr_q   <= !next_stall_d;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl against a
// transaction-level byte-array memory model.
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, rdy, clear, io_full;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        if_req, if_done;
   logic [31:0] if_addr, if_data;
   logic        lsb_req, lsb_done;
   logic [3:0]  lsb_type;
   logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;

   logic        r_rdy, r_clear, r_full;
   logic [7:0]  r_mem_din, r_mem_dout;
   logic [31:0] r_mem_a;
   logic        r_mem_wr;
   logic        r_if_req, r_if_done;
   logic [31:0] r_if_addr, r_if_data;
   logic        r_lsb_req, r_lsb_done;
   logic [3:0]  r_lsb_type;
   logic [31:0] r_lsb_addr, r_lsb_wdata, r_lsb_rdata;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  ram [0:65535];
   logic [7:0]  mdl [0:65535];
   logic        fill  = 1'b0;
   logic        pl_en = 1'b0;
   logic [15:0] pl_a  = '0;
   logic [7:0]  pl_d  = '0;

   mem_ctrl dut (
      .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .clear(clear),
      .io_buffer_full(io_full), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr), .if_req(if_req),
      .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .lsb_req(lsb_req), .lsb_type(lsb_type), .lsb_addr(lsb_addr),
      .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
   );

   mem_ctrl #(.LSB_FIRST(1'b0)) dut_rr (
      .clk_in(clk), .rst_in(rst_n), .rdy_in(r_rdy), .clear(r_clear),
      .io_buffer_full(r_full), .mem_din(r_mem_din),
      .mem_dout(r_mem_dout), .mem_a(r_mem_a), .mem_wr(r_mem_wr),
      .if_req(r_if_req), .if_addr(r_if_addr), .if_done(r_if_done),
      .if_data(r_if_data), .lsb_req(r_lsb_req),
      .lsb_type(r_lsb_type), .lsb_addr(r_lsb_addr),
      .lsb_wdata(r_lsb_wdata), .lsb_done(r_lsb_done),
      .lsb_rdata(r_lsb_rdata)
   );

   assign mem_din   = ram[mem_a[15:0]];
   assign r_mem_din = ram[r_mem_a[15:0]];

   // Byte-wide RAM: reads appear in the cycle mem_a is presented.
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 65536; i++) ram[i] <= 8'($urandom);
      end else begin
         if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
         if (pl_en) ram[pl_a] <= pl_d;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int nbeats(input logic [3:0] t);
      if (t == LB || t == LBU || t == SB) return 1;
      if (t == LH || t == LHU || t == SH) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a,
                                            input logic [3:0]  t);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < nbeats(t); i++)
         v = v | (32'(mdl[16'(a + 32'(i))]) << (8 * i));
      if (t == LB && v[7])  v = v | 32'hFFFF_FF00;
      if (t == LH && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      pl_en = 1'b1;
      pl_a  = a;
      pl_d  = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic xact(input bit lsb, input logic [3:0] t,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int extra, input string tag,
                       output logic [31:0] got);
      logic [3:0]  tt;
      logic [31:0] exp;
      logic [31:0] fa;
      int n, cyc, wr;
      tt  = lsb ? t : LW;
      n   = nbeats(tt);
      exp = ref_load(a, tt);
      cyc = 0;
      wr  = 0;
      fa  = '0;
      @(negedge clk);
      if (lsb) begin
         lsb_req   = 1'b1;
         lsb_type  = t;
         lsb_addr  = a;
         lsb_wdata = wd;
      end else begin
         if_req  = 1'b1;
         if_addr = a;
      end
      while (cyc < 60) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (mem_wr) begin
            if (wr == 0) fa = mem_a;
            wr++;
         end
         if (lsb ? lsb_done : if_done) break;
      end
      got     = lsb ? lsb_rdata : if_data;
      lsb_req = 1'b0;
      if_req  = 1'b0;
      chk({tag, " latency"}, 32'(cyc), 32'(n + 1 + extra));
      if (lsb && t[3]) begin
         chk({tag, " write beats"}, 32'(wr), 32'(n));
         chk({tag, " first addr"}, fa, a);
         for (int i = 0; i < n; i++) begin
            mdl[16'(a + 32'(i))] = wd[8*i +: 8];
            chk({tag, " ram byte"}, 32'(ram[16'(a + 32'(i))]),
                32'(wd[8*i +: 8]));
         end
      end else begin
         chk({tag, " data"}, got, exp);
         chk({tag, " no write"}, 32'(wr), 32'd0);
      end
   endtask

   logic [31:0] got;
   logic [31:0] ea, eb;
   logic [3:0]  codes [8];
   int          k, wr, lc, ic, nd;

   initial begin
      codes = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
      rst_n = 1'b0; rdy = 1'b1; clear = 1'b0; io_full = 1'b0;
      if_req = 1'b0; if_addr = '0;
      lsb_req = 1'b0; lsb_type = LW; lsb_addr = '0; lsb_wdata = '0;
      r_rdy = 1'b1; r_clear = 1'b0; r_full = 1'b0;
      r_if_req = 1'b0; r_if_addr = '0;
      r_lsb_req = 1'b0; r_lsb_type = LW; r_lsb_addr = '0;
      r_lsb_wdata = '0;
      fill = 1'b1;
      @(posedge clk);
      @(negedge clk);
      fill = 1'b0;
      poke(16'h0100, 8'h11); poke(16'h0101, 8'h22);
      poke(16'h0102, 8'h33); poke(16'h0103, 8'h44);
      poke(16'h0020, 8'h80);
      poke(16'h0022, 8'h80); poke(16'h0023, 8'hFF);
      for (int i = 0; i < 65536; i++) mdl[i] = ram[i];

      chk("rst mem_a", mem_a, 32'd0);
      chk("rst mem_wr", 32'(mem_wr), 32'd0);
      chk("rst mem_dout", 32'(mem_dout), 32'd0);
      chk("rst if_done", 32'(if_done), 32'd0);
      chk("rst lsb_done", 32'(lsb_done), 32'd0);
      chk("rst if_data", if_data, 32'd0);
      chk("rst lsb_rdata", lsb_rdata, 32'd0);
      chk("rst rr mem_wr", 32'(r_mem_wr), 32'd0);
      chk("rst rr mem_dout", 32'(r_mem_dout), 32'd0);
      rst_n = 1'b1;

      xact(1, LW, 32'h100, 0, 0, "lw", got);
      chk("lw const", got, 32'h4433_2211);
      xact(1, LB, 32'h20, 0, 0, "lb", got);
      chk("lb const", got, 32'hFFFF_FF80);
      xact(1, LBU, 32'h20, 0, 0, "lbu", got);
      chk("lbu const", got, 32'h0000_0080);
      xact(1, LHU, 32'h22, 0, 0, "lhu", got);
      chk("lhu const", got, 32'h0000_FF80);
      xact(1, LH, 32'h22, 0, 0, "lh", got);
      chk("lh const", got, 32'hFFFF_FF80);
      xact(1, SH, 32'h40, 32'h0000_BEEF, 0, "sh", got);
      chk("sh byte0", 32'(ram[16'h40]), 32'h0000_00EF);
      chk("sh byte1", 32'(ram[16'h41]), 32'h0000_00BE);
      xact(0, LW, 32'h100, 0, 0, "ifetch", got);
      chk("ifetch const", got, 32'h4433_2211);
      xact(1, LW, 32'hFFFF_FFFE, 0, 0, "lw wrap", got);

      // Simultaneous requests, LSB wins first.
      ea = ref_load(32'h100, LW);
      eb = ref_load(32'h200, LW);
      @(negedge clk);
      lsb_req = 1'b1; lsb_type = LW; lsb_addr = 32'h100;
      if_req = 1'b1; if_addr = 32'h200;
      k = 0; lc = 0; ic = 0;
      while (k < 60 && (lc == 0 || ic == 0)) begin
         @(posedge clk);
         @(negedge clk);
         k++;
         if (lsb_done) begin
            lc = k; lsb_req = 1'b0;
            chk("both lsb data", lsb_rdata, ea);
         end
         if (if_done) begin
            ic = k; if_req = 1'b0;
            chk("both if data", if_data, eb);
         end
      end
      lsb_req = 1'b0; if_req = 1'b0;
      chk("both lsb cycle", 32'(lc), 32'd5);
      chk("both if cycle", 32'(ic), 32'd11);

      // Round-robin instance alternates grants.
      @(negedge clk);
      r_lsb_req = 1'b1; r_lsb_type = LW; r_lsb_addr = 32'h100;
      r_if_req = 1'b1; r_if_addr = 32'h200;
      k = 0; nd = 0;
      while (k < 100 && nd < 6) begin
         @(posedge clk);
         @(negedge clk);
         k++;
         if (r_lsb_done) begin
            chk($sformatf("rr grant %0d", nd), 32'd1, 32'(nd % 2 == 0));
            chk("rr lsb data", r_lsb_rdata, ea);
            nd++;
         end
         if (r_if_done) begin
            chk($sformatf("rr grant %0d", nd), 32'd0, 32'(nd % 2 == 0));
            chk("rr if data", r_if_data, eb);
            nd++;
         end
      end
      r_lsb_req = 1'b0; r_if_req = 1'b0;
      chk("rr completions", 32'(nd), 32'd6);
      chk("rr no write", 32'(r_mem_wr), 32'd0);

      // Clear during an ifetch aborts it; refetch starts next cycle.
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h100;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear = 1'b0;
      chk("clr if_done", 32'(if_done), 32'd0);
      chk("clr mem_a", mem_a, 32'd0);
      k = 0; wr = 0;
      while (k < 20) begin
         @(posedge clk);
         @(negedge clk);
         k++;
         if (mem_wr) wr++;
         if (if_done) break;
      end
      if_req = 1'b0;
      chk("clr refetch latency", 32'(k), 32'd5);
      chk("clr refetch data", if_data, ref_load(32'h100, LW));
      chk("clr no write", 32'(wr), 32'd0);

      // Clear during a store does not disturb it.
      fork
         xact(1, SW, 32'h300, 32'hCAFE_F00D, 0, "sw clear", got);
         begin
            @(negedge clk);
            repeat (2) @(posedge clk);
            @(negedge clk);
            #1 clear = 1'b1;
            @(negedge clk);
            #1 clear = 1'b0;
         end
      join

      // IO store held while the UART buffer is full.
      io_full = 1'b1;
      fork
         xact(1, SB, 32'h0003_0000, 32'h5A, 3, "io stall", got);
         begin
            @(negedge clk);
            repeat (3) @(posedge clk);
            @(negedge clk);
            #1 io_full = 1'b0;
         end
      join

      // Global ready low freezes a store.
      fork
         xact(1, SW, 32'h500, 32'h1234_5678, 3, "rdy freeze", got);
         begin
            @(negedge clk);
            @(negedge clk);
            #1 rdy = 1'b0;
            #1 chk("rdy low mem_wr", 32'(mem_wr), 32'd0);
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            #1 rdy = 1'b1;
         end
      join

      // Reset in the middle of a word load.
      @(negedge clk);
      lsb_req = 1'b1; lsb_type = LW; lsb_addr = 32'h100;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst mem_a", mem_a, 32'd0);
      chk("midrst mem_wr", 32'(mem_wr), 32'd0);
      chk("midrst lsb_done", 32'(lsb_done), 32'd0);
      chk("midrst lsb_rdata", lsb_rdata, 32'd0);
      chk("midrst if_data", if_data, 32'd0);
      lsb_req = 1'b0;
      rst_n = 1'b1;
      nd = 0;
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
         if (lsb_done || if_done) nd++;
      end
      chk("midrst no done", 32'(nd), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         bit          l;
         logic [3:0]  t;
         logic [31:0] a, d;
         l = 1'($urandom_range(0, 1));
         t = codes[$urandom_range(0, 7)];
         a = $urandom;
         d = $urandom;
         xact(l, t, a, d, 0, $sformatf("rand%0d", i), got);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
